nv_nvdla_pdp_core_cal2d_avg_sat: RTL and testbench
==================================================

NV_NVDLA_PDP_CORE_CAL2D_AVG_SAT -- requirements
Module: NV_NVDLA_PDP_CORE_cal2d_avg_sat

Interface
REQ-001 The block SHALL have parameter LANES, default 8, number of data lanes per beat.
REQ-002 The block SHALL have parameter SUM_W, default 31, signed width of each input lane sum.
REQ-003 The block SHALL have parameter OUT_W, default 16, signed width of each output lane.
REQ-004 The block SHALL have parameter SB_W, default 7, width of the pass-through sideband.
REQ-005 The block SHALL have port nvdla_op_gated_clk_fp16  input  1  the single clock; all state on its rising edge.
REQ-006 The block SHALL have port nvdla_core_rst  input  1  reset; synchronous and active-high.
REQ-007 The block SHALL have port din_vld_d4  input  1  upstream beat valid.
REQ-008 The block SHALL have port din_rdy_d4  output  1  upstream beat accepted when high with din_vld_d4.
REQ-009 The block SHALL have port din_pd_d4  input  LANES*SUM_W+SB_W (255)  lane i sum at [i*SUM_W +: SUM_W]; sideband at [254:248].
REQ-010 The block SHALL have port reg2dp_pooling_method  input  2  0 = average, 1 = max, 2 = min, 3 = reserved (treated as max).
REQ-011 The block SHALL have port reg2dp_recip_kernel  input  17  unsigned Q1.16 reciprocal of kernel area.
REQ-012 The block SHALL have port op_load  input  1  single-cycle pulse clearing the saturation counter.
REQ-013 The block SHALL have port dout_vld  output  1  output beat valid.
REQ-014 The block SHALL have port dout_rdy  input  1  downstream ready.
REQ-015 The block SHALL have port dout_pd  output  LANES*OUT_W+SB_W (135)  lane i at [i*OUT_W +: OUT_W]; sideband at [134:128].
REQ-016 The block SHALL have port sat_cnt  output  32  count of saturated lanes since the last op_load.

Function
REQ-017 The block SHALL be a two-stage valid/ready pipeline: S1 (multiply), S2 (round/saturate); S2 drives dout_*.
REQ-018 Stage ready SHALL be !stage_valid || next_ready; din_rdy_d4 = !s1_vld || s2_rdy; s2_rdy = !dout_vld || dout_rdy.
REQ-019 Bubbles SHALL collapse; with dout_rdy held high, throughput SHALL be one beat per cycle and latency exactly 2 cycles from acceptance to dout_vld.
REQ-020 S1 SHALL capture, on acceptance, pooling_method, sideband and per-lane product; config is sampled per beat, so config changes affect only later-accepted beats.
REQ-021 Average mode: S1 product = signed sum * zero-extended recip, 48-bit signed, no truncation.
REQ-022 Max/min/reserved mode: S1 product = sum sign-extended and shifted left 16, so S2 rounding returns the sum unchanged.
REQ-023 S2 SHALL compute r = (product + 2^15) >>> 16 (arithmetic shift, round half toward +inf).
REQ-024 S2 SHALL saturate r to [-32768, 32767]; a lane is saturated when r lies outside that range.
REQ-025 Data registers SHALL hold value while stalled (valid high, next stage not ready); dout_pd SHALL be stable while dout_vld && !dout_rdy.
REQ-026 Sideband SHALL pass unchanged from din_pd_d4 to dout_pd, aligned with its beat.
REQ-027 sat_cnt SHALL add the number of saturated lanes (0..LANES) of each beat on the cycle that beat is loaded into S2.
REQ-028 sat_cnt SHALL saturate at 0xFFFFFFFF and SHALL NOT wrap.
REQ-029 When op_load and an S2 load coincide, sat_cnt SHALL become that beat's saturated-lane count.
REQ-030 Simultaneous accept into S1 and transfer S1->S2 in one cycle SHALL lose or duplicate no beat.

Reset
REQ-031 On nvdla_core_rst high at a clock edge: s1_vld = 0, dout_vld = 0, sat_cnt = 0; data registers may be left unreset.
REQ-032 While reset is asserted, din_rdy_d4 SHALL be 1 (pipe empty) and beats presented SHALL be discarded.
REQ-033 Reset asserted mid-operation SHALL drop all in-flight beats; the first post-reset output SHALL be a beat accepted after reset deasserts.

Verification
REQ-034 Avg, recip=0x1C72 (≈1/9), lane sum 90, dout_rdy=1 -> lane out 10 exactly 2 cycles after accept; sat_cnt unchanged.
REQ-035 Avg, recip=0x10000, lane sums 40000 and -40000 -> outputs 32767 and -32768; sat_cnt += 2.
REQ-036 Max mode, lane sum -5, sideband 0x55 -> lane out -5 (0xFFFB), sideband 0x55, 2-cycle latency.
REQ-037 Stream 4 beats, dout_rdy low for 3 cycles mid-stream -> din_rdy_d4 drops once both stages are full, dout_pd stable while stalled, all 4 beats delivered in order, no duplicate.
REQ-038 Preload sat_cnt = 0xFFFFFFFE, then beat with 8 saturated lanes -> sat_cnt = 0xFFFFFFFF; op_load in same cycle as a 3-saturated-lane beat -> sat_cnt = 3.
REQ-039 Two beats in flight, assert reset one cycle -> dout_vld = 0 and sat_cnt = 0 next cycle; neither beat appears at output.

Source files
------------

// File: rtl/nv_nvdla_pdp_core_cal2d_avg_sat.sv
// PDP 2D pooling finishing stage: per-lane reciprocal multiply (average) or pass-through
// (max/min), round half up, saturate to OUT_W, and count saturated lanes.
module nv_nvdla_pdp_core_cal2d_avg_sat #(
  parameter int LANES = 8,
  parameter int SUM_W = 31,
  parameter int OUT_W = 16,
  parameter int SB_W  = 7
) (
  input  logic                         nvdla_op_gated_clk_fp16,
  input  logic                         nvdla_core_rst,
  input  logic                         din_vld_d4,
  output logic                         din_rdy_d4,
  input  logic [LANES*SUM_W+SB_W-1:0]  din_pd_d4,
  input  logic [1:0]                   reg2dp_pooling_method,
  input  logic [16:0]                  reg2dp_recip_kernel,
  input  logic                         op_load,
  output logic                         dout_vld,
  input  logic                         dout_rdy,
  output logic [LANES*OUT_W+SB_W-1:0]  dout_pd,
  output logic [31:0]                  sat_cnt
);
  localparam int PROD_W = SUM_W + 17;
  localparam int RND_W  = PROD_W - 15;
  localparam int CNT_W  = $clog2(LANES + 1);
  localparam logic [1:0] METHOD_AVG = 2'd0;
  localparam logic signed [PROD_W:0]  RND_HALF = {{(PROD_W-15){1'b0}}, 1'b1, 15'b0};
  localparam logic signed [RND_W-1:0] LANE_MAX = {{(RND_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RND_W-1:0] LANE_MIN = {{(RND_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Valid/ready: a beat moves when valid && ready are both high in the same cycle; a stage
  // is ready when it is empty or its current beat leaves this cycle, so bubbles collapse.
  logic s1_vld;
  logic s2_rdy;
  logic din_acc;
  logic s2_load;

  assign s2_rdy     = !dout_vld || dout_rdy;
  assign din_rdy_d4 = nvdla_core_rst || !s1_vld || s2_rdy;
  assign din_acc    = din_vld_d4 && din_rdy_d4;
  assign s2_load    = s1_vld && s2_rdy;

  always_ff @(posedge nvdla_op_gated_clk_fp16) begin
    if (nvdla_core_rst) begin
      s1_vld   <= 1'b0;
      dout_vld <= 1'b0;
    end else begin
      if (din_rdy_d4) s1_vld <= din_vld_d4;
      if (s2_rdy) dout_vld <= s1_vld;
    end
  end

  // S1: max/min beats are pre-shifted so the shared rounding step returns the sum unchanged.
  logic signed [SUM_W-1:0]  lane_sum;
  logic signed [PROD_W-1:0] sum_ext;
  logic signed [PROD_W-1:0] recip_ext;
  logic signed [PROD_W-1:0] prod_nxt [LANES];

  always_comb begin
    lane_sum  = '0;
    sum_ext   = '0;
    recip_ext = $signed({{(PROD_W-17){1'b0}}, reg2dp_recip_kernel});
    for (int i = 0; i < LANES; i++) begin
      lane_sum    = din_pd_d4[i*SUM_W +: SUM_W];
      sum_ext     = PROD_W'(lane_sum);
      prod_nxt[i] = (reg2dp_pooling_method == METHOD_AVG) ? sum_ext * recip_ext
                                                          : sum_ext <<< 16;
    end
  end

  logic signed [PROD_W-1:0] s1_prod [LANES];
  logic [SB_W-1:0]          s1_sb;

  always_ff @(posedge nvdla_op_gated_clk_fp16) begin
    if (din_acc) begin
      for (int i = 0; i < LANES; i++) s1_prod[i] <= prod_nxt[i];
      s1_sb <= din_pd_d4[LANES*SUM_W +: SB_W];
    end
  end

  // S2: round half toward +inf, then clamp to the signed OUT_W range.
  logic signed [PROD_W:0]  rnd_sum;
  logic signed [RND_W-1:0] lane_r;
  logic                    sat_i;
  logic [OUT_W-1:0]        lane_out [LANES];
  logic [CNT_W-1:0]        sat_lanes;

  always_comb begin
    rnd_sum   = '0;
    lane_r    = '0;
    sat_i     = 1'b0;
    sat_lanes = '0;
    for (int i = 0; i < LANES; i++) begin
      rnd_sum = (PROD_W+1)'(s1_prod[i]) + RND_HALF;
      lane_r  = rnd_sum[PROD_W:16];
      sat_i   = (lane_r > LANE_MAX) || (lane_r < LANE_MIN);
      if (lane_r > LANE_MAX)      lane_out[i] = LANE_MAX[OUT_W-1:0];
      else if (lane_r < LANE_MIN) lane_out[i] = LANE_MIN[OUT_W-1:0];
      else                        lane_out[i] = lane_r[OUT_W-1:0];
      sat_lanes = sat_lanes + CNT_W'(sat_i);
    end
  end

  always_ff @(posedge nvdla_op_gated_clk_fp16) begin
    if (s2_load) begin
      for (int i = 0; i < LANES; i++) dout_pd[i*OUT_W +: OUT_W] <= lane_out[i];
      dout_pd[LANES*OUT_W +: SB_W] <= s1_sb;
    end
  end

  // The counter sticks at all-ones; op_load restarts it from the beat being loaded, if any.
  logic [32:0] sat_sum;
  assign sat_sum = {1'b0, sat_cnt} + 33'(sat_lanes);

  always_ff @(posedge nvdla_op_gated_clk_fp16) begin
    if (nvdla_core_rst)  sat_cnt <= '0;
    else if (op_load)    sat_cnt <= s2_load ? 32'(sat_lanes) : '0;
    else if (s2_load)    sat_cnt <= sat_sum[32] ? '1 : sat_sum[31:0];
  end

endmodule

// File: tb/tb_nv_nvdla_pdp_core_cal2d_avg_sat.sv
// Bench for the PDP average/saturate stage: directed corner cases plus a random stream,
// scored against an arithmetic lane model and an expected-beat queue.
module tb_nv_nvdla_pdp_core_cal2d_avg_sat;
  localparam int LANES  = 8;
  localparam int SUM_W  = 31;
  localparam int OUT_W  = 16;
  localparam int SB_W   = 7;
  localparam int IN_W   = LANES*SUM_W + SB_W;
  localparam int OUT_PW = LANES*OUT_W + SB_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              din_vld, din_rdy, op_load, dout_vld, dout_rdy;
  logic [IN_W-1:0]   din_pd;
  logic [1:0]        meth;
  logic [16:0]       recip;
  logic [OUT_PW-1:0] dout_pd;
  logic [31:0]       sat_cnt;

  nv_nvdla_pdp_core_cal2d_avg_sat dut (
    .nvdla_op_gated_clk_fp16 (clk),
    .nvdla_core_rst          (rst),
    .din_vld_d4              (din_vld),
    .din_rdy_d4              (din_rdy),
    .din_pd_d4               (din_pd),
    .reg2dp_pooling_method   (meth),
    .reg2dp_recip_kernel     (recip),
    .op_load                 (op_load),
    .dout_vld                (dout_vld),
    .dout_rdy                (dout_rdy),
    .dout_pd                 (dout_pd),
    .sat_cnt                 (sat_cnt)
  );

  // scoreboard state
  logic [OUT_PW-1:0] exp_q[$];
  logic [31:0]       exp_sat;
  int                n_cmp  = 0;
  int                n_fail = 0;
  bit                stream_done;
  logic [IN_W-1:0]   bp[4];

  task automatic check(input string tag, input logic [OUT_PW-1:0] obs, input logic [OUT_PW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // reference model: lane arithmetic straight from the rounding/saturation rules
  function automatic logic [OUT_PW-1:0] model(input logic [IN_W-1:0] pd, input logic [1:0] m,
                                              input logic [16:0] rc, output int nsat);
    logic [OUT_PW-1:0] o;
    longint s, r;
    o = '0;
    nsat = 0;
    for (int i = 0; i < LANES; i++) begin
      s = longint'($signed(pd[i*SUM_W +: SUM_W]));
      if (m == 2'd0) r = (s * longint'(rc) + 32768) >>> 16;
      else           r = s;
      if (r > 32767)       begin r = 32767;  nsat++; end
      else if (r < -32768) begin r = -32768; nsat++; end
      o[i*OUT_W +: OUT_W] = r[15:0];
    end
    o[OUT_PW-1 -: SB_W] = pd[IN_W-1 -: SB_W];
    return o;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input int n);
    longint t;
    t = longint'(a) + longint'(n);
    return (t > 64'sh0_FFFF_FFFF) ? 32'hFFFF_FFFF : t[31:0];
  endfunction

  function automatic logic [IN_W-1:0] mk_pd(input int v[LANES], input logic [SB_W-1:0] sb);
    logic [IN_W-1:0] pd;
    int t;
    pd = '0;
    for (int i = 0; i < LANES; i++) begin
      t = v[i];
      pd[i*SUM_W +: SUM_W] = t[SUM_W-1:0];
    end
    pd[IN_W-1 -: SB_W] = sb;
    return pd;
  endfunction

  function automatic logic [IN_W-1:0] rand_pd();
    logic [IN_W-1:0] pd;
    int v;
    for (int i = 0; i < LANES; i++) begin
      case ($urandom_range(0, 3))
        0:       v = int'($urandom_range(0, 200)) - 100;
        1:       v = int'($urandom_range(0, 80000)) - 40000;
        2:       v = int'($urandom_range(0, 2097152)) - 1048576;
        default: v = int'($urandom());
      endcase
      pd[i*SUM_W +: SUM_W] = v[SUM_W-1:0];
    end
    pd[IN_W-1 -: SB_W] = SB_W'($urandom());
    return pd;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [IN_W-1:0] pd, input logic [1:0] m, input logic [16:0] rc);
    int  nsat;
    int  guard;
    bit  acc;
    din_vld = 1'b1;
    din_pd  = pd;
    meth    = m;
    recip   = rc;
    acc     = 1'b0;
    guard   = 0;
    while (!acc) begin
      @(negedge clk);
      acc = din_rdy;
      if (acc) begin
        exp_q.push_back(model(pd, m, rc, nsat));
        exp_sat = sat_add(exp_sat, nsat);
      end
      tick();
      guard++;
      if (!acc && guard > 50) begin
        check("accept_timeout", OUT_PW'(acc), OUT_PW'(1));
        break;
      end
    end
    din_vld = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    din_vld  = 1'b0;
    dout_rdy = 1'b1;
    while (exp_q.size() != 0 && g < 30) begin
      tick();
      g++;
    end
    check("drain_left", OUT_PW'(exp_q.size()), '0);
    repeat (3) tick();
  endtask

  // output monitor: in-order beat compare and hold-while-stalled check
  logic [OUT_PW-1:0] prev_pd;
  bit                prev_stall = 1'b0;
  always @(negedge clk) begin
    if (rst) prev_stall = 1'b0;
    else begin
      if (prev_stall) check("stall_hold", dout_pd, prev_pd);
      if (dout_vld && dout_rdy) begin
        if (exp_q.size() == 0) check("extra_beat", OUT_PW'(dout_vld), '0);
        else                   check("beat", dout_pd, exp_q.pop_front());
      end
      prev_stall = dout_vld && !dout_rdy;
      prev_pd    = dout_pd;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    din_vld  = 1'b1;
    din_pd   = mk_pd('{123, 456, 7, 7, 7, 7, 7, 7}, 7'h11);
    meth     = 2'd0;
    recip    = 17'h1C72;
    op_load  = 1'b0;
    dout_rdy = 1'b1;
    exp_sat  = '0;

    // reset: always ready, beats presented meanwhile are dropped
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_din_rdy", OUT_PW'(din_rdy), OUT_PW'(1));
      tick();
    end
    check("rst_dout_vld", OUT_PW'(dout_vld), '0);
    check("rst_sat_cnt", OUT_PW'(sat_cnt), '0);
    rst     = 1'b0;
    din_vld = 1'b0;
    repeat (3) tick();
    check("post_rst_idle", OUT_PW'(dout_vld), '0);

    // average by ~1/9: 90 -> 10, two-cycle latency
    send(mk_pd('{90, 90, 90, 90, 90, 90, 90, 90}, 7'h2A), 2'd0, 17'h1C72);
    check("avg_lat_s1", OUT_PW'(dout_vld), '0);
    tick();
    check("avg_lat_out", OUT_PW'(dout_vld), OUT_PW'(1));
    check("avg_lane0", OUT_PW'(dout_pd[15:0]), OUT_PW'(16'd10));
    check("avg_sat_cnt", OUT_PW'(sat_cnt), '0);
    tick();

    // saturation both directions
    send(mk_pd('{40000, -40000, 0, 0, 0, 0, 0, 0}, 7'h03), 2'd0, 17'h10000);
    tick();
    check("sat_pos", OUT_PW'(dout_pd[15:0]), OUT_PW'(16'h7FFF));
    check("sat_neg", OUT_PW'(dout_pd[31:16]), OUT_PW'(16'h8000));
    check("sat_cnt_2", OUT_PW'(sat_cnt), OUT_PW'(32'd2));
    tick();

    // max mode pass-through with sideband
    send(mk_pd('{-5, -5, -5, -5, -5, -5, -5, -5}, 7'h55), 2'd1, 17'h1C72);
    tick();
    check("max_vld", OUT_PW'(dout_vld), OUT_PW'(1));
    check("max_lane0", OUT_PW'(dout_pd[15:0]), OUT_PW'(16'hFFFB));
    check("max_sb", OUT_PW'(dout_pd[OUT_PW-1 -: SB_W]), OUT_PW'(7'h55));
    drain();

    // random stream with random downstream back-pressure
    stream_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 48; k++) begin
          send(rand_pd(), 2'($urandom_range(0, 3)), 17'($urandom_range(0, 131071)));
          repeat ($urandom_range(0, 2)) tick();
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          dout_rdy = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
    join
    drain();
    check("rand_sat_cnt", OUT_PW'(sat_cnt), OUT_PW'(exp_sat));

    // four beats, downstream stalls three cycles once both stages hold a beat
    for (int k = 0; k < 4; k++) bp[k] = rand_pd();
    send(bp[0], 2'd0, 17'h4000);
    send(bp[1], 2'd0, 17'h4000);
    dout_rdy = 1'b0;
    din_vld  = 1'b1;
    din_pd   = bp[2];
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("full_din_rdy", OUT_PW'(din_rdy), '0);
      tick();
    end
    dout_rdy = 1'b1;
    send(bp[2], 2'd0, 17'h4000);
    send(bp[3], 2'd0, 17'h4000);
    drain();

    // counter sticks at all-ones, then op_load coinciding with a 3-lane beat
    force dut.sat_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.sat_cnt;
    exp_sat = 32'hFFFF_FFFE;
    send(mk_pd('{40000, 40000, 40000, 40000, 40000, 40000, 40000, 40000}, 7'h01), 2'd0, 17'h10000);
    drain();
    check("sat_cnt_stick", OUT_PW'(sat_cnt), OUT_PW'(32'hFFFF_FFFF));
    send(mk_pd('{40000, -40000, 40000, 5, 5, 5, 5, 5}, 7'h02), 2'd0, 17'h10000);
    op_load = 1'b1;
    tick();
    op_load = 1'b0;
    exp_sat = 32'd3;
    check("op_load_coincide", OUT_PW'(sat_cnt), OUT_PW'(exp_sat));
    op_load = 1'b1;
    tick();
    op_load = 1'b0;
    exp_sat = '0;
    check("op_load_clear", OUT_PW'(sat_cnt), '0);
    drain();

    // reset with two beats in flight drops both
    dout_rdy = 1'b0;
    send(mk_pd('{40000, 40000, 40000, 40000, 40000, 40000, 40000, 40000}, 7'h0F), 2'd0, 17'h10000);
    send(rand_pd(), 2'd2, 17'h1C72);
    check("inflight_vld", OUT_PW'(dout_vld), OUT_PW'(1));
    check("inflight_sat", OUT_PW'(sat_cnt), OUT_PW'(32'd8));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    exp_sat = '0;
    check("midrst_vld", OUT_PW'(dout_vld), '0);
    check("midrst_sat", OUT_PW'(sat_cnt), '0);
    dout_rdy = 1'b1;
    repeat (4) tick();
    send(mk_pd('{-300, 300, 1, -1, 0, 70000, -70000, 9}, 7'h7E), 2'd2, 17'h0);
    tick();
    check("post_rst_first", OUT_PW'(dout_vld), OUT_PW'(1));
    drain();
    check("final_sat_cnt", OUT_PW'(sat_cnt), OUT_PW'(exp_sat));

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
